mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL give the number of SIC requesters (2..8).
REQ-002 Parameter ID_WIDTH, default 4, SHALL give the issue-id width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  SHALL carry one per-SIC memory request bit, held until grant.
REQ-006 req_id  input  NUM_REQ*ID_WIDTH  SHALL carry the per-SIC issue id of the requesting instruction.
REQ-007 req_write  input  NUM_REQ  SHALL select the per-SIC operation: 1=store, 0=load.
REQ-008 req_addr  input  NUM_REQ*32  SHALL carry the per-SIC word address.
REQ-009 req_wdata  input  NUM_REQ*32  SHALL carry the per-SIC store data.
REQ-010 head_id  input  ID_WIDTH  SHALL give the oldest in-flight issue id, the age reference.
REQ-011 grant  output  NUM_REQ  SHALL be a one-hot completion pulse to the owning SIC.
REQ-012 rdata  output  32  SHALL carry load data, valid when grant is asserted.
REQ-013 m_valid  output  1  SHALL mark the memory command as valid.
REQ-014 m_write, m_addr[31:0], m_wdata[31:0]  output  SHALL carry the memory command fields.
REQ-015 m_ready  input  1  SHALL signal that memory accepted the command.
REQ-016 m_rvalid  input  1  SHALL signal memory response; m_rdata[31:0] input carries load data.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-018 IDLE: if any req_valid, select winner, latch owner index, write, addr, wdata and owner id; go to ISSUE next cycle; else stay.
REQ-019 Winner SHALL minimise age = (req_id - head_id) mod 2^ID_WIDTH; equal age goes to the lowest index.
REQ-020 ISSUE: m_valid=1 with latched fields; on m_ready go to WAIT, else hold fields stable.
REQ-021 WAIT: on m_rvalid go to IDLE; grant[owner] = m_rvalid && req_valid[owner] && req_id[owner]==owner id (combinational); rdata = m_rdata passthrough.
REQ-022 Stores SHALL also wait for m_rvalid (the write ack) before grant.
REQ-023 Flush: if the owner drops req_valid or changes req_id mid-transaction, the memory transaction SHALL complete but no grant SHALL be pulsed.
REQ-024 Minimum latency SHALL be req seen in IDLE at cycle N, m_valid at N+1, grant at N+2 (m_ready and m_rvalid same-cycle responsive).
REQ-025 Back-to-back: arbitration SHALL restart in IDLE the cycle after the grant (one bubble); a granted SIC is expected to deassert req_valid after grant.
REQ-026 Only one transaction SHALL be outstanding; requests arriving in ISSUE/WAIT wait for IDLE.
REQ-027 Outside WAIT-with-m_rvalid, grant=0 and rdata=0; outside ISSUE, m_valid=0 and m_write/m_addr/m_wdata=0.
REQ-028 The id comparison SHALL wrap correctly (head_id=14, ids 15 and 1 with ID_WIDTH=4: 15 is older).

Reset
REQ-029 On rst_n low, at any time including mid-transaction, the FSM SHALL enter IDLE and latched fields and owner SHALL clear to 0.
REQ-030 All outputs SHALL be 0 during reset; any pending memory response after reset SHALL be ignored.

Structure
REQ-031 The FSM state enum and an age-distance function SHALL live in the shared structs package.
REQ-032 One sub-module, age_select (combinational oldest-of-N picker returning a one-hot result and an index), SHALL be used.

Verification
REQ-033 Single load: SIC2 req id=5, head=5, addr=0x100; m_ready and m_rvalid immediate, m_rdata=0xDEADBEEF -> grant=0b0100 at N+2, rdata=0xDEADBEEF.
REQ-034 Age pick: head=14, SIC0 id=1, SIC3 id=15 simultaneous -> SIC3 served first, SIC0 granted in a second transaction.
REQ-035 Stall: m_ready low 3 cycles -> m_valid held 4 cycles with stable addr; grant only after m_rvalid.
REQ-036 Flush: SIC1 drops req_valid during WAIT -> m_rvalid arrives, grant stays 0, FSM returns to IDLE.
REQ-037 Reset in WAIT: assert rst_n low -> m_valid=0 and grant=0 immediately; a later m_rvalid produces no grant.
REQ-038 Tie: SIC0 and SIC1 both id=3, head=3 -> SIC0 wins.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types and helpers for the memory-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int c_MAX_ID_WIDTH = 16;
    localparam int c_WORD_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Distance of an issue id from the head, modulo 2^width; smaller is older.
    function automatic logic [c_MAX_ID_WIDTH-1:0] age_dist(
        input logic [c_MAX_ID_WIDTH-1:0] id,
        input logic [c_MAX_ID_WIDTH-1:0] head,
        input int unsigned               width
    );
        logic [c_MAX_ID_WIDTH-1:0] mask;
        mask = {c_MAX_ID_WIDTH{1'b1}} >> (c_MAX_ID_WIDTH - width);
        return (id - head) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_age_select.sv
`default_nettype none
// ============================================================================
// Module   : age_select
// Brief    : Combinational picker of the oldest valid requester (ties -> lowest index).
// Revision : 1.0  initial release
// ============================================================================
module age_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic [NUM_REQ-1:0]          i_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0] i_ids,
    input  logic [ID_WIDTH-1:0]         i_head,
    output logic [NUM_REQ-1:0]          o_sel_onehot,
    output logic [$clog2(NUM_REQ)-1:0]  o_sel_idx,
    output logic                        o_sel_any
);

    localparam int c_IDX_WIDTH = $clog2(NUM_REQ);

    logic [ID_WIDTH-1:0]    w_age [NUM_REQ];
    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_best_age;
    logic [c_IDX_WIDTH-1:0] w_best_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
            assign w_age[gi] = ID_WIDTH'(age_dist(
                c_MAX_ID_WIDTH'(i_ids[gi*ID_WIDTH +: ID_WIDTH]),
                c_MAX_ID_WIDTH'(i_head),
                ID_WIDTH));
        end
    endgenerate

    // Strict less-than keeps the first (lowest-index) requester on equal age.
    always_comb begin
        w_found    = 1'b0;
        w_best_age = '0;
        w_best_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_valid[i] && (!w_found || (w_age[i] < w_best_age))) begin
                w_found    = 1'b1;
                w_best_age = w_age[i];
                w_best_idx = c_IDX_WIDTH'(i);
            end
        end
    end

    assign o_sel_any    = w_found;
    assign o_sel_idx    = w_best_idx;
    assign o_sel_onehot = w_found ? (NUM_REQ'(1) << w_best_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Age-ordered single-outstanding arbiter from N SIC requesters to one memory port.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]       req_id,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*c_WORD_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*c_WORD_WIDTH-1:0]   req_wdata,
    input  logic [ID_WIDTH-1:0]               head_id,
    output logic [NUM_REQ-1:0]                grant,
    output logic [c_WORD_WIDTH-1:0]           rdata,
    output logic                              m_valid,
    output logic                              m_write,
    output logic [c_WORD_WIDTH-1:0]           m_addr,
    output logic [c_WORD_WIDTH-1:0]           m_wdata,
    input  logic                              m_ready,
    input  logic                              m_rvalid,
    input  logic [c_WORD_WIDTH-1:0]           m_rdata
);

    localparam int c_IDX_WIDTH = $clog2(NUM_REQ);

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [c_IDX_WIDTH-1:0]    r_owner;
    logic [ID_WIDTH-1:0]       r_owner_id;
    logic                      r_write;
    logic [c_WORD_WIDTH-1:0]   r_addr;
    logic [c_WORD_WIDTH-1:0]   r_wdata;

    logic [ID_WIDTH-1:0]       w_req_id    [NUM_REQ];
    logic [c_WORD_WIDTH-1:0]   w_req_addr  [NUM_REQ];
    logic [c_WORD_WIDTH-1:0]   w_req_wdata [NUM_REQ];

    logic [NUM_REQ-1:0]        w_sel_onehot;
    logic [c_IDX_WIDTH-1:0]    w_sel_idx;
    logic                      w_sel_any;
    logic                      w_sel_write;
    logic [ID_WIDTH-1:0]       w_sel_id;
    logic [c_WORD_WIDTH-1:0]   w_sel_addr;
    logic [c_WORD_WIDTH-1:0]   w_sel_wdata;
    logic                      w_owner_live;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_id[gi]    = req_id[gi*ID_WIDTH +: ID_WIDTH];
            assign w_req_addr[gi]  = req_addr[gi*c_WORD_WIDTH +: c_WORD_WIDTH];
            assign w_req_wdata[gi] = req_wdata[gi*c_WORD_WIDTH +: c_WORD_WIDTH];
        end
    endgenerate

    age_select #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_age_select (
        .i_valid      (req_valid),
        .i_ids        (req_id),
        .i_head       (head_id),
        .o_sel_onehot (w_sel_onehot),
        .o_sel_idx    (w_sel_idx),
        .o_sel_any    (w_sel_any)
    );

    // One-hot AND-OR mux of the winning requester's command fields.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_id    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_onehot[i]) begin
                w_sel_write = w_sel_write | req_write[i];
                w_sel_id    = w_sel_id    | w_req_id[i];
                w_sel_addr  = w_sel_addr  | w_req_addr[i];
                w_sel_wdata = w_sel_wdata | w_req_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_sel_any) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (m_ready)   w_state_nxt = ST_WAIT;
            ST_WAIT:  if (m_rvalid)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are captured once in IDLE and stay frozen until the next arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= '0;
            r_owner_id <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if ((r_state == ST_IDLE) && w_sel_any) begin
            r_owner    <= w_sel_idx;
            r_owner_id <= w_sel_id;
            r_write    <= w_sel_write;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
        end
    end

    // A flushed owner (request dropped or reused id) still drains but gets no grant.
    assign w_owner_live = req_valid[r_owner] && (w_req_id[r_owner] == r_owner_id);

    always_comb begin
        grant   = '0;
        rdata   = '0;
        m_valid = 1'b0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (r_state)
            ST_ISSUE: begin
                m_valid = 1'b1;
                m_write = r_write;
                m_addr  = r_addr;
                m_wdata = r_wdata;
            end
            ST_WAIT: begin
                if (m_rvalid) begin
                    rdata          = m_rdata;
                    grant[r_owner] = w_owner_live;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench with a memory responder and an age-order reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 4;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ID_WIDTH-1:0] req_id;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ*32-1:0]       req_addr;
    logic [NUM_REQ*32-1:0]       req_wdata;
    logic [ID_WIDTH-1:0]         head_id;
    logic [NUM_REQ-1:0]          grant;
    logic [31:0]                 rdata;
    logic                        m_valid;
    logic                        m_write;
    logic [31:0]                 m_addr;
    logic [31:0]                 m_wdata;
    logic                        m_ready;
    logic                        m_rvalid;
    logic [31:0]                 m_rdata;

    mem_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .head_id   (head_id),
        .grant     (grant),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } cmd_t;

    typedef struct {
        int          idx;
        logic [31:0] rd;
    } gnt_t;

    cmd_t exp_cmd[$];
    gnt_t exp_gnt[$];
    int   gorder[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
    endtask

    // Memory contents: address-derived default, one fixed word for the latency scenario.
    function automatic logic [31:0] mdefault(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] rmem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : mdefault(a);
    endfunction

    function automatic int model_age(input int id, input int head);
        return ((id - head) % (1 << ID_WIDTH) + (1 << ID_WIDTH)) % (1 << ID_WIDTH);
    endfunction

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          n_hs = 0;
    int          n_rsp = 0;
    int          gcnt [NUM_REQ];
    int          mv_run = 0;
    int          last_mv_len = 0;
    int          first_mv_cyc = 0;
    int          last_gnt_cyc = 0;
    logic [NUM_REQ-1:0] last_gnt_vec = '0;
    bit          prev_stall = 0;
    logic        prev_w;
    logic [31:0] prev_a, prev_d;
    logic        hs_w;
    logic [31:0] hs_a, hs_d;
    bit          s_mv = 0, s_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cmd_t c;
        gnt_t g;
        int   idx;
        s_mv  = m_valid;
        s_rdy = m_ready;
        if (rst_n) begin
            if (m_valid && prev_stall) begin
                chk("stall_addr_stable",  m_addr,  prev_a);
                chk("stall_wdata_stable", m_wdata, prev_d);
                chk("stall_write_stable", 32'(m_write), 32'(prev_w));
            end
            if (!m_valid)
                chk("idle_cmd_zero", 32'(m_write) | m_addr | m_wdata, 32'h0);
            if (m_valid) begin
                if (mv_run == 0) first_mv_cyc = cyc;
                mv_run++;
            end
            if (m_valid && m_ready) begin
                n_hs++;
                hs_w = m_write; hs_a = m_addr; hs_d = m_wdata;
                last_mv_len = mv_run;
                mv_run = 0;
                if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
                else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_write", 32'(m_write), 32'(c.wr));
                    chk("cmd_addr",  m_addr,  c.addr);
                    chk("cmd_wdata", m_wdata, c.wd);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_w = m_write; prev_a = m_addr; prev_d = m_wdata;
            if (m_rvalid) n_rsp++;
            if (grant != '0) begin
                chk("grant_onehot", 32'($countones(grant)), 32'd1);
                idx = 0;
                for (int i = NUM_REQ - 1; i >= 0; i--) if (grant[i]) idx = i;
                gcnt[idx]++;
                gorder.push_back(idx);
                last_gnt_cyc = cyc;
                last_gnt_vec = grant;
                if (exp_gnt.size() == 0) fail_now("unexpected_grant");
                else begin
                    g = exp_gnt.pop_front();
                    chk("grant_idx",   32'(idx), 32'(g.idx));
                    chk("grant_rdata", rdata, g.rd);
                end
            end else if (!m_rvalid) begin
                chk("idle_rdata_zero", rdata, 32'h0);
            end
        end else begin
            mv_run = 0;
            prev_stall = 0;
        end
    end

    // ---------------- memory responder ----------------
    int dly_mode     = 0;   // 0 random latency, 1 immediate, 2 long, 3 one-cycle
    int stall_cycles = 0;
    int stale_req    = 0;

    initial begin
        int          seen_hs = 0;
        int          stall_used = 0;
        int          stale_done = 0;
        bit          pend = 0;
        int          dly = 0;
        logic        pw;
        logic [31:0] pa;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            if (s_mv && !s_rdy && stall_used < stall_cycles) stall_used++;
            if (n_hs != seen_hs) begin
                seen_hs = n_hs;
                pend = 1; pw = hs_w; pa = hs_a;
                if (pw) rmem[pa] = hs_d;
                case (dly_mode)
                    1:       dly = 0;
                    2:       dly = 6;
                    3:       dly = 1;
                    default: dly = $urandom_range(0, 2);
                endcase
            end
            if (!rst_n) pend = 0;
            if (stale_done != stale_req) begin
                stale_done++;
                m_rvalid = 1'b1;
                m_rdata  = 32'hBAD0_0BAD;
            end else if (pend) begin
                if (dly == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = pw ? 32'h0 : (rmem.exists(pa) ? rmem[pa] : mdefault(pa));
                    pend = 0;
                end else dly--;
            end
            if (stall_used < stall_cycles) m_ready = 1'b0;
            else if (dly_mode == 1)        m_ready = 1'b1;
            else                           m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    logic [NUM_REQ-1:0]  st_valid, st_wr;
    logic [ID_WIDTH-1:0] st_id [NUM_REQ];
    logic [31:0]         st_addr [NUM_REQ];
    logic [31:0]         st_wd [NUM_REQ];
    logic [ID_WIDTH-1:0] st_head;
    int                  rnd_cyc;

    task automatic stage(input int i, input int id, input bit wr, input logic [31:0] addr);
        st_valid[i] = 1'b1;
        st_id[i]    = ID_WIDTH'(id);
        st_wr[i]    = wr;
        st_addr[i]  = addr;
        st_wd[i]    = $urandom;
    endtask

    task automatic drive_sic(input int i);
        req_valid[i] = st_valid[i];
        req_id[i*ID_WIDTH +: ID_WIDTH] = st_id[i];
        req_write[i] = st_wr[i];
        req_addr[i*32 +: 32]  = st_addr[i];
        req_wdata[i*32 +: 32] = st_wd[i];
    endtask

    task automatic push_expect(input int i, input bit with_grant);
        logic [31:0] rd;
        exp_cmd.push_back('{st_wr[i], st_addr[i], st_wd[i]});
        if (st_wr[i]) begin
            mmem[st_addr[i]] = st_wd[i];
            rd = 32'h0;
        end else rd = model_rd(st_addr[i]);
        if (with_grant) exp_gnt.push_back('{i, rd});
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((exp_cmd.size() != 0 || exp_gnt.size() != 0 || m_valid) && b < 200) begin
            @(posedge clk); #1; b++;
        end
        if (b >= 200) begin
            fail_now("idle_timeout");
            exp_cmd.delete(); exp_gnt.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input logic [NUM_REQ-1:0] mask, input int gstart[NUM_REQ]);
        logic [NUM_REQ-1:0] left = mask;
        int b = 0;
        while (left != '0 && b < 400) begin
            @(posedge clk); #1; b++;
            for (int i = 0; i < NUM_REQ; i++)
                if (left[i] && gcnt[i] != gstart[i]) begin
                    left[i] = 1'b0;
                    req_valid[i] = 1'b0;
                end
        end
        if (left != '0) begin
            fail_now("grant_timeout");
            req_valid = '0;
            exp_cmd.delete(); exp_gnt.delete();
        end
    endtask

    // Expected order: increasing age from head, lowest index first within an age.
    task automatic do_round();
        int order[$];
        int gstart[NUM_REQ];
        wait_idle();
        rnd_cyc = cyc;
        head_id = st_head;
        gorder.delete();
        for (int a = 0; a < (1 << ID_WIDTH); a++)
            for (int i = 0; i < NUM_REQ; i++)
                if (st_valid[i] && model_age(int'(st_id[i]), int'(st_head)) == a)
                    order.push_back(i);
        foreach (order[k]) push_expect(order[k], 1'b1);
        gstart = gcnt;
        for (int i = 0; i < NUM_REQ; i++) drive_sic(i);
        wait_grants(st_valid, gstart);
    endtask

    initial begin
        int gstart[NUM_REQ];
        int h0, r0, g0, b;
        rst_n = 1'b0;
        req_valid = '0; req_id = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        head_id = '0;
        st_valid = '0; st_wr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gcnt[i] = 0; st_id[i] = '0; st_addr[i] = '0; st_wd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", 32'(m_valid), 32'h0);
        chk("reset_grant",   32'(grant),   32'h0);
        chk("reset_rdata",   rdata,        32'h0);
        chk("reset_m_addr",  m_addr,       32'h0);
        rst_n = 1'b1;

        // single load with immediate memory: latency N -> N+1 -> N+2
        dly_mode = 1;
        st_valid = '0; st_head = 4'd5;
        stage(2, 5, 1'b0, 32'h100);
        do_round();
        chk("lat_m_valid_cycle", 32'(first_mv_cyc - rnd_cyc), 32'd1);
        chk("lat_grant_cycle",   32'(last_gnt_cyc - rnd_cyc), 32'd2);
        chk("lat_grant_vec",     32'(last_gnt_vec),           32'h4);

        // wrapped ages: head 14, id 15 is older than id 1
        dly_mode = 0;
        st_valid = '0; st_head = 4'd14;
        stage(0, 1, 1'b0, 32'h1004);
        stage(3, 15, 1'b1, 32'h1004);
        do_round();
        if (gorder.size() == 2) begin
            chk("age_first",  32'(gorder[0]), 32'd3);
            chk("age_second", 32'(gorder[1]), 32'd0);
        end else fail_now("age_grant_count");

        // equal age goes to the lower index
        st_valid = '0; st_head = 4'd3;
        stage(0, 3, 1'b0, 32'h1008);
        stage(1, 3, 1'b0, 32'h100C);
        do_round();
        if (gorder.size() == 2) chk("tie_first", 32'(gorder[0]), 32'd0);
        else fail_now("tie_grant_count");

        // m_ready held low for three ISSUE cycles
        dly_mode = 1;
        stall_cycles = stall_cycles + 3;
        st_valid = '0; st_head = 4'd0;
        stage(1, 2, 1'b1, 32'h1010);
        do_round();
        chk("stall_m_valid_len", 32'(last_mv_len), 32'd4);

        // flush: SIC1 withdraws during WAIT
        dly_mode = 3;
        st_valid = '0; st_head = 4'd8;
        stage(1, 9, 1'b0, 32'h1014);
        wait_idle();
        head_id = st_head;
        push_expect(1, 1'b0);
        h0 = n_hs; r0 = n_rsp; g0 = gcnt[1];
        drive_sic(1);
        b = 0;
        while (n_hs == h0 && b < 100) begin @(posedge clk); #1; b++; end
        req_valid[1] = 1'b0;
        b = 0;
        while (n_rsp == r0 && b < 100) begin @(posedge clk); #1; b++; end
        if (b >= 100) fail_now("flush_response");
        repeat (2) @(posedge clk);
        #1;
        chk("flush_no_grant", 32'(gcnt[1] - g0), 32'd0);

        // reset while waiting for the response, then a stale response
        dly_mode = 2;
        st_valid = '0; st_head = 4'd7;
        stage(0, 7, 1'b0, 32'h1018);
        wait_idle();
        head_id = st_head;
        push_expect(0, 1'b0);
        h0 = n_hs;
        drive_sic(0);
        b = 0;
        while (n_hs == h0 && b < 100) begin @(posedge clk); #1; b++; end
        if (b >= 100) fail_now("reset_test_handshake");
        rst_n = 1'b0;
        #1;
        chk("rst_wait_m_valid", 32'(m_valid), 32'h0);
        chk("rst_wait_grant",   32'(grant),   32'h0);
        chk("rst_wait_rdata",   rdata,        32'h0);
        chk("rst_wait_m_addr",  m_addr,       32'h0);
        repeat (2) @(posedge clk);
        #1;
        push_expect(0, 1'b1);
        gstart = gcnt;
        rst_n = 1'b1;
        stale_req = stale_req + 1;
        wait_grants(st_valid, gstart);

        // randomized rounds
        dly_mode = 0;
        repeat (40) begin
            st_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            st_head  = ID_WIDTH'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                st_id[i]   = ID_WIDTH'($urandom);
                st_wr[i]   = 1'($urandom);
                st_addr[i] = 32'h1000 + 32'(4 * $urandom_range(0, 7));
                st_wd[i]   = $urandom;
            end
            do_round();
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
